interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_pkg.sv | 36 +++
 rtl/interrupt_controller_edge_detect.sv | 32 +++
 rtl/interrupt_controller.sv | 106 ++++++++++
 tb/tb_interrupt_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared coprocessor constants for the interrupt controller.
// Holds the controller state encoding, the cause codes reported to the CPU,
// the source bit positions inside the pending vector, and the priority
// selector used when a request is raised.
package interrupt_controller_pkg;

    localparam int PC_W    = 16;
    localparam int NUM_SRC = 2;

    // Bit positions of each source inside the pending vector
    localparam int SRC_OVF  = 0;
    localparam int SRC_USER = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Cause codes are one-hot over the pending vector, so a latched cause
    // doubles as the mask of the pending bit it refers to.
    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_OVF  = 2'b01;
    localparam logic [1:0] CAUSE_USER = 2'b10;

    // Overflow outranks the user button.
    function automatic logic [1:0] pick_cause(input logic [NUM_SRC-1:0] pend);
        if (pend[SRC_OVF])
            return CAUSE_OVF;
        else if (pend[SRC_USER])
            return CAUSE_USER;
        else
            return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/interrupt_controller_edge_detect.sv
// edge_detect: single-source rising-edge detector.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   sig  - level input from the event source
//   rise - one-cycle high when sig goes 0 -> 1
// A source that is already high when reset releases is not treated as an
// event: detection only arms after the source has been seen low once.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic prev;
    logic armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev <= sig;
            if (!sig)
                armed <= 1'b1;
        end
    end

    assign rise = sig & ~prev & armed;

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: two-source interrupt controller for the CPU
// coprocessor. Rising edges on overflow / userInput set sticky pending bits;
// an IDLE -> REQ -> SERVICE state machine raises irq, latches cause and epc,
// and returns to IDLE on reti.
// Ports:
//   CLK, Reset          - clock, asynchronous active-high reset
//   overflow, userInput - event sources (rising-edge detected)
//   interruptsEnabled   - global enable
//   pc                  - address of the instruction committing this cycle
//   irqAck, reti        - CPU handshake pulses
//   irq, mode           - request line, handler-mode flag
//   cause, epc          - latched cause code and exception PC
module interrupt_controller
    import interrupt_controller_pkg::*;
(
    input  logic            CLK,
    input  logic            Reset,
    input  logic            overflow,
    input  logic            userInput,
    input  logic            interruptsEnabled,
    input  logic [PC_W-1:0] pc,
    input  logic            irqAck,
    input  logic            reti,
    output logic            irq,
    output logic            mode,
    output logic [1:0]      cause,
    output logic [PC_W-1:0] epc
);

    state_t               state, state_nxt;
    logic [NUM_SRC-1:0]   pend, pend_nxt, pend_clr, rises;
    logic [1:0]           cause_r, cause_nxt;
    logic [PC_W-1:0]      epc_r, epc_nxt;

    edge_detect u_edge_ovf (
        .clk  (CLK),
        .rst  (Reset),
        .sig  (overflow),
        .rise (rises[SRC_OVF])
    );

    edge_detect u_edge_user (
        .clk  (CLK),
        .rst  (Reset),
        .sig  (userInput),
        .rise (rises[SRC_USER])
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            pend    <= '0;
            cause_r <= CAUSE_NONE;
            epc_r   <= '0;
        end else begin
            state   <= state_nxt;
            pend    <= pend_nxt;
            cause_r <= cause_nxt;
            epc_r   <= epc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = cause_r;
        epc_nxt   = epc_r;
        pend_clr  = '0;
        case (state)
            ST_IDLE: begin
                if (interruptsEnabled && (|pend)) begin
                    state_nxt = ST_REQ;
                    cause_nxt = pick_cause(pend);
                    epc_nxt   = pc;
                end
            end
            ST_REQ: begin
                // Acknowledge wins over a simultaneous enable drop.
                if (irqAck) begin
                    state_nxt = ST_SERVICE;
                    pend_clr  = cause_r;  // one-hot cause == pending mask
                end else if (!interruptsEnabled) begin
                    state_nxt = ST_IDLE;
                    cause_nxt = CAUSE_NONE;
                end
            end
            ST_SERVICE: begin
                if (reti) begin
                    state_nxt = ST_IDLE;
                    cause_nxt = CAUSE_NONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cause_nxt = CAUSE_NONE;
            end
        endcase
        // A fresh edge in the clearing cycle keeps the bit set.
        pend_nxt = (pend & ~pend_clr) | rises;
    end

    assign irq   = (state == ST_REQ);
    assign mode  = (state == ST_SERVICE);
    assign cause = cause_r;
    assign epc   = epc_r;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        overflow, userInput, interruptsEnabled, irqAck, reti;
    logic [15:0] pc;
    logic        irq, mode;
    logic [1:0]  cause;
    logic [15:0] epc;

    int checks = 0;
    int errors = 0;

    interrupt_controller dut (
        .CLK               (CLK),
        .Reset             (Reset),
        .overflow          (overflow),
        .userInput         (userInput),
        .interruptsEnabled (interruptsEnabled),
        .pc                (pc),
        .irqAck            (irqAck),
        .reti              (reti),
        .irq               (irq),
        .mode              (mode),
        .cause             (cause),
        .epc               (epc)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit        ovf, usr, en;
        bit [15:0] pc;
        bit        ack, ret;
        bit        x_irq, x_mode;
        bit [1:0]  x_cause;
        bit [15:0] x_epc;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    bit        m_req, m_svc;
    int        m_cause;
    bit [15:0] m_epc;
    bit        m_pend[2];
    bit        m_prev[2];
    bit        m_seen_low[2];

    function automatic bit [19:0] outs();
        return {irq, mode, cause, epc};
    endfunction

    task automatic check(input string name, input bit [19:0] act, input bit [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit o, u, e, input bit [15:0] p, input bit a, r);
        overflow = o; userInput = u; interruptsEnabled = e; pc = p; irqAck = a; reti = r;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive(0, 0, 0, 16'h0, 0, 0);
        repeat (2) cyc();
        check("reset_state", outs(), 20'h0);
        Reset = 1'b0;
    endtask

    task automatic add(input bit o, u, e, input bit [15:0] p, input bit a, r,
                       input bit xi, xm, input bit [1:0] xc, input bit [15:0] xe);
        vec_t v;
        v.ovf = o; v.usr = u; v.en = e; v.pc = p; v.ack = a; v.ret = r;
        v.x_irq = xi; v.x_mode = xm; v.x_cause = xc; v.x_epc = xe;
        vecs.push_back(v);
    endtask

    function automatic void model_reset();
        m_req = 0; m_svc = 0; m_cause = 0; m_epc = '0;
        for (int s = 0; s < 2; s++) begin
            m_pend[s] = 0; m_prev[s] = 0; m_seen_low[s] = 0;
        end
    endfunction

    // Advance the model across one clock edge using the currently driven inputs.
    function automatic void model_step();
        bit in_s[2];
        bit ev[2];
        in_s[0] = overflow;
        in_s[1] = userInput;
        for (int s = 0; s < 2; s++) begin
            ev[s] = in_s[s] && !m_prev[s] && m_seen_low[s];
            if (!in_s[s]) m_seen_low[s] = 1;
            m_prev[s] = in_s[s];
        end
        if (m_req) begin
            if (irqAck) begin
                m_req = 0; m_svc = 1; m_pend[m_cause-1] = 0;
            end else if (!interruptsEnabled) begin
                m_req = 0; m_cause = 0;
            end
        end else if (m_svc) begin
            if (reti) begin
                m_svc = 0; m_cause = 0;
            end
        end else if (interruptsEnabled && (m_pend[0] || m_pend[1])) begin
            m_req = 1;
            m_cause = m_pend[0] ? 1 : 2;
            m_epc = pc;
        end
        for (int s = 0; s < 2; s++)
            if (ev[s]) m_pend[s] = 1;
    endfunction

    function automatic bit [19:0] model_outs();
        return {m_req, m_svc, 2'(m_cause), m_epc};
    endfunction

    initial begin
        int rises_seen;
        bit prev_irq;
        bit got;

        Reset = 1'b1;
        drive(0, 0, 0, 16'h0, 0, 0);
        #3;
        check("reset_async_initial", outs(), 20'h0);

        //    ovf usr en pc        ack ret  irq mode cause epc
        add(0, 0, 0, 16'h0040, 0, 0,   0, 0, 2'd0, 16'h0000);
        add(0, 1, 1, 16'h0040, 0, 0,   0, 0, 2'd0, 16'h0000);
        add(0, 1, 1, 16'h0040, 0, 0,   1, 0, 2'd2, 16'h0040);
        add(0, 1, 1, 16'h0040, 1, 0,   0, 1, 2'd2, 16'h0040);
        add(0, 0, 1, 16'h0040, 0, 0,   0, 1, 2'd2, 16'h0040);
        add(0, 0, 1, 16'h0040, 0, 1,   0, 0, 2'd0, 16'h0040);
        add(0, 0, 1, 16'h0040, 0, 0,   0, 0, 2'd0, 16'h0040);
        add(1, 1, 1, 16'h0100, 0, 0,   0, 0, 2'd0, 16'h0040);
        add(1, 1, 1, 16'h0100, 0, 0,   1, 0, 2'd1, 16'h0100);
        add(0, 0, 1, 16'h0100, 1, 0,   0, 1, 2'd1, 16'h0100);
        add(0, 0, 1, 16'h0100, 0, 1,   0, 0, 2'd0, 16'h0100);
        add(0, 0, 1, 16'h0200, 0, 0,   1, 0, 2'd2, 16'h0200);
        add(0, 0, 1, 16'h0200, 1, 0,   0, 1, 2'd2, 16'h0200);
        add(0, 0, 1, 16'h0200, 0, 1,   0, 0, 2'd0, 16'h0200);
        add(1, 0, 1, 16'h0300, 0, 0,   0, 0, 2'd0, 16'h0200);
        add(1, 0, 1, 16'h0300, 0, 0,   1, 0, 2'd1, 16'h0300);
        add(0, 0, 0, 16'h0300, 0, 0,   0, 0, 2'd0, 16'h0300);
        add(0, 0, 0, 16'h0300, 0, 0,   0, 0, 2'd0, 16'h0300);
        add(0, 0, 1, 16'h0304, 0, 0,   1, 0, 2'd1, 16'h0304);
        add(1, 0, 1, 16'h0304, 1, 0,   0, 1, 2'd1, 16'h0304);
        add(1, 0, 1, 16'h0304, 1, 0,   0, 1, 2'd1, 16'h0304);
        add(0, 0, 1, 16'h0304, 0, 1,   0, 0, 2'd0, 16'h0304);
        add(0, 0, 1, 16'h0400, 0, 0,   1, 0, 2'd1, 16'h0400);
        add(0, 0, 1, 16'h0400, 0, 1,   1, 0, 2'd1, 16'h0400);
        add(0, 0, 1, 16'h0400, 1, 0,   0, 1, 2'd1, 16'h0400);
        add(0, 0, 1, 16'h0400, 0, 1,   0, 0, 2'd0, 16'h0400);
        add(0, 0, 1, 16'h0400, 0, 0,   0, 0, 2'd0, 16'h0400);

        do_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].ovf, vecs[i].usr, vecs[i].en, vecs[i].pc, vecs[i].ack, vecs[i].ret);
            cyc();
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].x_irq, vecs[i].x_mode, vecs[i].x_cause, vecs[i].x_epc});
        end

        // Disabled overflow pulse stays pending until enable arrives
        do_reset();
        drive(0, 0, 0, 16'h0010, 0, 0); cyc();
        drive(1, 0, 0, 16'h0010, 0, 0); cyc();
        drive(0, 0, 0, 16'h0010, 0, 0); cyc();
        check("disabled_no_irq_a", {19'h0, irq}, 20'h0);
        cyc();
        check("disabled_no_irq_b", {19'h0, irq}, 20'h0);
        drive(0, 0, 1, 16'h0010, 0, 0);
        got = 0;
        for (int k = 0; k < 2 && !got; k++) begin
            cyc();
            if (irq) got = 1;
        end
        check("enable_late_irq", {19'h0, irq}, 20'h1);
        check("enable_late_cause", {18'h0, cause}, 20'h1);

        // Held userInput yields a single request
        do_reset();
        drive(0, 0, 1, 16'h0020, 0, 0); cyc();
        rises_seen = 0;
        prev_irq = 0;
        for (int k = 0; k < 14; k++) begin
            drive(0, k < 10, 1, 16'h0020, irq, mode);
            cyc();
            if (irq && !prev_irq) rises_seen++;
            prev_irq = irq;
        end
        check("held_single_request", 20'(rises_seen), 20'd1);

        // Source high across reset release is not an event
        Reset = 1'b1;
        drive(0, 1, 1, 16'h0030, 0, 0);
        repeat (2) cyc();
        Reset = 1'b0;
        repeat (4) cyc();
        check("held_through_reset", outs(), 20'h0);
        drive(0, 0, 1, 16'h0030, 0, 0); cyc();
        drive(0, 1, 1, 16'h0030, 0, 0); cyc();
        cyc();
        check("rerise_after_reset", outs(), {1'b1, 1'b0, 2'd2, 16'h0030});

        // Asynchronous reset mid-SERVICE and mid-REQ
        drive(0, 1, 1, 16'h0030, 1, 0); cyc();
        check("enter_service", outs(), {1'b0, 1'b1, 2'd2, 16'h0030});
        #2 Reset = 1'b1;
        #1 check("reset_mid_service", outs(), 20'h0);
        cyc();
        Reset = 1'b0;
        drive(0, 0, 1, 16'h0050, 0, 0); cyc();
        drive(1, 0, 1, 16'h0050, 0, 0); cyc();
        cyc();
        check("enter_req", outs(), {1'b1, 1'b0, 2'd1, 16'h0050});
        #2 Reset = 1'b1;
        #1 check("reset_mid_req", outs(), 20'h0);
        cyc();
        Reset = 1'b0;

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(199) == 0) begin
                #2 Reset = 1'b1;
                #1 model_reset();
                check($sformatf("rand_async_reset%0d", n), outs(), model_outs());
                drive($urandom_range(1), $urandom_range(1), 1, 16'($urandom), 0, 0);
                cyc();
                check($sformatf("rand_in_reset%0d", n), outs(), model_outs());
                Reset = 1'b0;
            end else begin
                drive($urandom_range(2) == 0, $urandom_range(2) == 0,
                      $urandom_range(7) != 0, 16'($urandom),
                      irq ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0),
                      mode ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0));
                model_step();
                cyc();
                check($sformatf("rand%0d", n), outs(), model_outs());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
